// File: rtl/vga_line_buffer.sv
// rtl/vga_line_buffer.sv - ping-pong line buffer between a pixel stream source and VGA timing
// Two line banks: the writer fills one while the display replays the other.
module vga_line_buffer #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  input  logic              disp_de,
  input  logic              disp_line_end,
  input  logic              disp_frame_start,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic              frame_err
);

  localparam int LC_W = $clog2(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W:0]   RD_END  = (ADDR_W+1)'(H_ACTIVE);
  localparam logic [LC_W-1:0]   LINES   = LC_W'(V_ACTIVE);

  typedef enum logic [1:0] {WAIT_SOF, FILL, DROP, DONE} wr_state_t;

  wr_state_t         state;
  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];
  logic [1:0]        bank_full;
  logic [ADDR_W:0]   bank_len [0:1];
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   rd_addr;
  logic [LC_W-1:0]   line_cnt;
  logic [LC_W-1:0]   line_cnt_nxt;
  logic              line_ok;
  logic [DATA_W-1:0] rd_q;
  logic              rd_hit;
  logic              accept;
  logic              wr_en;
  logic              line_done;
  logic              line_wrap;
  logic              ok_now;
  logic [1:0]        set_full;
  logic [1:0]        clr_full;

  always_comb begin
    s_ready = 1'b0;
    if (!rst && !disp_frame_start) begin
      case (state)
        WAIT_SOF, DROP: s_ready = 1'b1;
        FILL:           s_ready = !bank_full[wr_bank];
        default:        s_ready = 1'b0;
      endcase
    end
  end

  assign accept       = s_valid && s_ready;
  assign wr_en        = accept && ((state == WAIT_SOF && s_sof) || state == FILL);
  assign line_wrap    = (wr_addr == WR_LAST) && !s_eol;
  assign line_done    = wr_en && (s_eol || wr_addr == WR_LAST);
  assign line_cnt_nxt = line_cnt + LC_W'(1);
  // First pixel of a line uses the bank state directly, before line_ok has latched it.
  assign ok_now       = (rd_addr == '0) ? bank_full[rd_bank] : line_ok;
  assign set_full     = line_done ? (2'b01 << wr_bank) : 2'b00;
  assign clr_full     = (disp_line_end && line_ok) ? (2'b01 << rd_bank) : 2'b00;
  assign pix_data     = rd_hit ? rd_q : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= s_data;
    rd_q <= mem[{rd_bank, rd_addr[ADDR_W-1:0]}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_SOF;
      bank_full   <= '0;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      line_cnt    <= '0;
      line_ok     <= 1'b0;
      rd_hit      <= 1'b0;
      pix_valid   <= 1'b0;
      underflow   <= 1'b0;
      frame_err   <= 1'b0;
    end else if (disp_frame_start) begin
      state       <= WAIT_SOF;
      bank_full   <= '0;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      line_cnt    <= '0;
      line_ok     <= 1'b0;
      rd_hit      <= 1'b0;
      pix_valid   <= 1'b0;
    end else begin
      bank_full <= (bank_full & ~clr_full) | set_full;

      if (line_done) begin
        bank_len[wr_bank] <= {1'b0, wr_addr} + (ADDR_W+1)'(1);
        wr_bank  <= !wr_bank;
        wr_addr  <= '0;
        line_cnt <= line_cnt_nxt;
        if (line_wrap) frame_err <= 1'b1;
        if (line_cnt_nxt == LINES) state <= DONE;
        else if (line_wrap)        state <= DROP;
        else                       state <= FILL;
      end else if (wr_en) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        state   <= FILL;
      end

      if (accept) begin
        case (state)
          WAIT_SOF: if (!s_sof) frame_err <= 1'b1;
          FILL:     if (s_sof) frame_err <= 1'b1;
          DROP:     if (s_eol) state <= (line_cnt == LINES) ? DONE : FILL;
          default:  ;
        endcase
      end

      pix_valid <= disp_de;
      rd_hit    <= disp_de && ok_now && (rd_addr < bank_len[rd_bank]);
      if (disp_de) begin
        if (rd_addr == '0) begin
          line_ok <= bank_full[rd_bank];
          if (!bank_full[rd_bank]) underflow <= 1'b1;
        end
        if (rd_addr != RD_END) rd_addr <= rd_addr + (ADDR_W+1)'(1);
      end

      // A late line keeps rd_bank so it is shown on the following display line.
      if (disp_line_end) begin
        rd_addr <= '0;
        line_ok <= 1'b0;
        if (line_ok) rd_bank <= !rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_vga_line_buffer.sv
// tb/tb_vga_line_buffer.sv - directed scenario bench for vga_line_buffer
// Small geometry (8x4) so every boundary is reachable in a few hundred cycles.
module tb_vga_line_buffer;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 24;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_sof;
  logic          s_eol;
  logic          disp_de;
  logic          disp_line_end;
  logic          disp_frame_start;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          underflow;
  logic          frame_err;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  vga_line_buffer #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .disp_de(disp_de), .disp_line_end(disp_line_end), .disp_frame_start(disp_frame_start),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow), .frame_err(frame_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0;
    disp_de = 1'b0; disp_line_end = 1'b0; disp_frame_start = 1'b0;
    step; step;
    rst = 1'b0;
  endtask

  task automatic frame_start;
    disp_frame_start = 1'b1;
    step;
    disp_frame_start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic sof, input logic eol);
    bit done_b;
    done_b = 1'b0;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    for (int i = 0; i < 50 && !done_b; i++) begin
      #1;
      if (s_ready) done_b = 1'b1;
      step;
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    if (!done_b) begin
      ntot++;
      $display("FAIL beat_timeout data=%h: s_ready stayed 0 for 50 cycles, want 1", d);
    end
  endtask

  task automatic push_line(input int base, input int n, input bit sof, input int eol_at);
    for (int i = 0; i < n; i++)
      send_beat(24'(base + i), sof && (i == 0), i == eol_at);
  endtask

  task automatic display_line(input string name, input int base, input int nvalid);
    logic [DW-1:0] exp;
    for (int i = 0; i < H; i++) begin
      disp_de = 1'b1;
      step;
      exp = (i < nvalid) ? 24'(base + i) : 24'h0;
      ntot++;
      if ({pix_valid, pix_data} !== {1'b1, exp})
        $display("FAIL %s px%0d: got valid=%b data=%h, want valid=1 data=%h", name, i, pix_valid, pix_data, exp);
      else npass++;
    end
    disp_de = 1'b0;
    disp_line_end = 1'b1;
    step;
    disp_line_end = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b1; s_data = 24'h123456; s_sof = 1'b1; s_eol = 1'b0;
    disp_de = 1'b0; disp_line_end = 1'b0; disp_frame_start = 1'b0;
    step; step;
    ntot++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else npass++;
    ntot++; if ({pix_valid, pix_data} !== 25'h0) $display("FAIL rst_pix: got %b/%h want 0/000000", pix_valid, pix_data); else npass++;
    ntot++; if ({underflow, frame_err} !== 2'b00) $display("FAIL rst_flags: got %b%b want 00", underflow, frame_err); else npass++;
    s_valid = 1'b0; s_sof = 1'b0;
    rst = 1'b0;
    #1;
    ntot++; if (s_ready !== 1'b1) $display("FAIL rst_wait_sof_ready: got %b want 1", s_ready); else npass++;
  endtask

  task automatic test_stream;
    do_reset;
    frame_start;
    push_line(8'h00, 8, 1'b1, 7);
    push_line(8'h10, 8, 1'b0, 7);
    display_line("stream_l0", 8'h00, 8);
    push_line(8'h20, 8, 1'b0, 7);
    display_line("stream_l1", 8'h10, 8);
    push_line(8'h30, 8, 1'b0, 7);
    display_line("stream_l2", 8'h20, 8);
    display_line("stream_l3", 8'h30, 8);
    ntot++; if ({underflow, frame_err} !== 2'b00) $display("FAIL stream_flags: got %b%b want 00", underflow, frame_err); else npass++;
  endtask

  task automatic test_done_and_reset;
    int k;
    k = 0;
    s_valid = 1'b1; s_data = 24'hABCDEF;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (s_ready) k++;
      step;
    end
    s_valid = 1'b0;
    ntot++; if (k !== 0) $display("FAIL done_stall: got %0d beats accepted want 0", k); else npass++;
    frame_start;
    ntot++; if (s_ready !== 1'b1) $display("FAIL done_restart_ready: got %b want 1", s_ready); else npass++;
    send_beat(24'h77, 1'b0, 1'b0);
    ntot++; if (frame_err !== 1'b1) $display("FAIL done_nosof_err: got %b want 1", frame_err); else npass++;
    disp_de = 1'b1;
    step; step;
    ntot++; if ({underflow, pix_valid} !== 2'b11) $display("FAIL done_mid_line: got uf=%b valid=%b want 1 1", underflow, pix_valid); else npass++;
    rst = 1'b1; s_valid = 1'b1; s_sof = 1'b1;
    step;
    ntot++; if ({pix_valid, pix_data} !== 25'h0) $display("FAIL midrst_pix: got %b/%h want 0/000000", pix_valid, pix_data); else npass++;
    ntot++; if ({underflow, frame_err, s_ready} !== 3'b000) $display("FAIL midrst_flags: got uf=%b fe=%b rdy=%b want 000", underflow, frame_err, s_ready); else npass++;
    rst = 1'b0; disp_de = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic test_backpressure;
    int k;
    do_reset;
    frame_start;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      s_valid = 1'b1; s_data = 24'((k / 8) * 16 + (k % 8)); s_sof = (k == 0); s_eol = ((k % 8) == 7);
      #1;
      if (s_ready) k++;
      step;
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    ntot++; if (k !== 16) $display("FAIL bp_first_burst: got %0d beats want 16", k); else npass++;
    ntot++; if (s_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", s_ready); else npass++;
    display_line("bp_l0", 8'h00, 8);
    for (int c = 0; c < 20; c++) begin
      s_valid = 1'b1; s_data = 24'((k / 8) * 16 + (k % 8)); s_sof = 1'b0; s_eol = ((k % 8) == 7);
      #1;
      if (s_ready) k++;
      step;
    end
    s_valid = 1'b0; s_eol = 1'b0;
    ntot++; if (k !== 24) $display("FAIL bp_second_burst: got %0d total beats want 24", k); else npass++;
    display_line("bp_l1", 8'h10, 8);
    display_line("bp_l2", 8'h20, 8);
    ntot++; if ({underflow, frame_err} !== 2'b00) $display("FAIL bp_flags: got %b%b want 00", underflow, frame_err); else npass++;
  endtask

  task automatic test_underflow;
    do_reset;
    frame_start;
    display_line("uf_black", 0, 0);
    ntot++; if (underflow !== 1'b1) $display("FAIL uf_flag: got %b want 1", underflow); else npass++;
    push_line(8'h00, 8, 1'b1, 7);
    display_line("uf_late_l0", 8'h00, 8);
    ntot++; if (frame_err !== 1'b0) $display("FAIL uf_frame_err: got %b want 0", frame_err); else npass++;
  endtask

  task automatic test_short_long;
    do_reset;
    frame_start;
    push_line(8'h00, 5, 1'b1, 4);
    display_line("short_l0", 8'h00, 5);
    ntot++; if (frame_err !== 1'b0) $display("FAIL short_frame_err: got %b want 0", frame_err); else npass++;
    push_line(8'h10, 10, 1'b0, 9);
    display_line("long_l1", 8'h10, 8);
    ntot++; if (frame_err !== 1'b1) $display("FAIL long_frame_err: got %b want 1", frame_err); else npass++;
    push_line(8'h20, 8, 1'b0, 7);
    display_line("after_drop_l2", 8'h20, 8);
    ntot++; if (underflow !== 1'b0) $display("FAIL long_underflow: got %b want 0", underflow); else npass++;
  endtask

  task automatic test_sof_errors;
    do_reset;
    frame_start;
    send_beat(24'h55, 1'b0, 1'b0);
    send_beat(24'h66, 1'b0, 1'b0);
    ntot++; if (frame_err !== 1'b1) $display("FAIL presof_frame_err: got %b want 1", frame_err); else npass++;
    push_line(8'h00, 8, 1'b1, 7);
    display_line("presof_l0", 8'h00, 8);
    push_line(8'h10, 8, 1'b0, 7);
    s_valid = 1'b1; s_sof = 1'b1; s_data = 24'hAA; disp_frame_start = 1'b1;
    #1;
    ntot++; if (s_ready !== 1'b0) $display("FAIL fs_coincident_ready: got %b want 0", s_ready); else npass++;
    step;
    s_valid = 1'b0; s_sof = 1'b0; disp_frame_start = 1'b0;
    display_line("fs_cleared", 0, 0);
    ntot++; if ({underflow, frame_err} !== 2'b11) $display("FAIL fs_sticky: got uf=%b fe=%b want 1 1", underflow, frame_err); else npass++;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_done_and_reset;
    test_backpressure;
    test_underflow;
    test_short_long;
    test_sof_errors;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, want finished");
    $fatal(1);
  end

endmodule
